// File: rtl/output_port_arbiter_pkg.sv
// Shared router constants: arbiter FSM encoding and packet header layout.
// The receiver's size arithmetic must use pkt_len() so both ends agree on L.
package output_port_arbiter_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    localparam int OFF_SRC  = 0;
    localparam int OFF_DST  = OFF_SRC + 1;
    localparam int OFF_SIZE = OFF_DST + 1;
    localparam int PKT_OVH  = 4;
    localparam int SIZE_W   = 3;

    // Total packet length: SRC, DST, SIZE, CRC plus SIZE[2:0] data bytes.
    function automatic int pkt_len(input logic [SIZE_W-1:0] size);
        return int'(size) + PKT_OVH;
    endfunction

endpackage

// File: rtl/output_port_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first set request scanning upward from ptr, with wrap.
// The pointer register lives in the parent so it only advances on packet completion.
module rr_arbiter #(
    parameter int N_REQ = 3,
    parameter int IDX_W = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N_REQ-1:0] grant
);

    // Scan from farthest to nearest offset so the nearest requester overwrites last.
    always_comb begin
        logic [IDX_W-1:0] idx;
        grant = '0;
        idx   = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            idx = IDX_W'((int'(ptr) + k) % N_REQ);
            if (req[idx]) begin
                grant      = '0;
                grant[idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/output_port_arbiter.sv
// Output link arbiter: grants one packet buffer at a time (packet-granular round-robin),
// streams its packet out byte-by-byte under downstream stall, and pulses release on the CRC.
module output_port_arbiter
    import output_port_arbiter_pkg::*;
#(
    parameter int N_REQ  = 3,
    parameter int PTR_SZ = 4,
    parameter int UWIDTH = 8
) (
    input  logic                    clk1,
    input  logic                    rst,
    input  logic [N_REQ-1:0]        req_i,
    input  logic [N_REQ*UWIDTH-1:0] rdata_i,
    input  logic                    stop_i,
    output logic [PTR_SZ-1:0]       raddr_o,
    output logic [N_REQ-1:0]        grant_o,
    output logic [N_REQ-1:0]        release_o,
    output logic [UWIDTH-1:0]       pdata_o,
    output logic                    packet_valid_o
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    state_t            state_q, state_nx;
    logic [IDX_W-1:0]  ptr_q, ptr_nx, ptr_after;
    logic [PTR_SZ-1:0] len_q, len_nx, raddr_nx;
    logic [N_REQ-1:0]  grant_nx, release_nx, pick;
    logic [UWIDTH-1:0] rdata_g, pdata_nx;
    logic              valid_nx, last_byte;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_rr (
        .req   (req_i),
        .ptr   (ptr_q),
        .grant (pick)
    );

    // Grant is one-hot, so an AND-OR mux selects the owning buffer's byte.
    always_comb begin
        rdata_g = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant_o[i]) begin
                rdata_g = rdata_g | rdata_i[i*UWIDTH +: UWIDTH];
            end
        end
    end

    always_comb begin
        ptr_after = ptr_q;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant_o[i]) begin
                ptr_after = (i == N_REQ - 1) ? '0 : IDX_W'(i + 1);
            end
        end
    end

    // Length is only meaningful after the SIZE byte, hence the lower bound on raddr.
    assign last_byte = (raddr_o >= PTR_SZ'(PKT_OVH - 1)) &&
                       (raddr_o == len_q - PTR_SZ'(1));

    always_comb begin
        state_nx   = state_q;
        grant_nx   = grant_o;
        raddr_nx   = raddr_o;
        len_nx     = len_q;
        ptr_nx     = ptr_q;
        pdata_nx   = pdata_o;
        valid_nx   = 1'b0;
        release_nx = '0;
        case (state_q)
            IDLE: begin
                grant_nx = '0;
                raddr_nx = '0;
                if (!stop_i && (|req_i)) begin
                    grant_nx = pick;
                    state_nx = SEND;
                end
            end
            SEND: begin
                if (!stop_i) begin
                    pdata_nx = rdata_g;
                    valid_nx = 1'b1;
                    raddr_nx = raddr_o + PTR_SZ'(1);
                    if (raddr_o == PTR_SZ'(OFF_SIZE)) begin
                        len_nx = PTR_SZ'(pkt_len(rdata_g[SIZE_W-1:0]));
                    end
                    if (last_byte) begin
                        release_nx = grant_o;
                        ptr_nx     = ptr_after;
                        grant_nx   = '0;
                        raddr_nx   = '0;
                        state_nx   = IDLE;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk1 or negedge rst) begin
        if (!rst) begin
            state_q        <= IDLE;
            ptr_q          <= '0;
            len_q          <= '0;
            raddr_o        <= '0;
            grant_o        <= '0;
            release_o      <= '0;
            pdata_o        <= '0;
            packet_valid_o <= 1'b0;
        end else begin
            state_q        <= state_nx;
            ptr_q          <= ptr_nx;
            len_q          <= len_nx;
            raddr_o        <= raddr_nx;
            grant_o        <= grant_nx;
            release_o      <= release_nx;
            pdata_o        <= pdata_nx;
            packet_valid_o <= valid_nx;
        end
    end

    a_grant_onehot: assert property (@(posedge clk1) disable iff (!rst) $onehot0(grant_o));
    a_release_onehot: assert property (@(posedge clk1) disable iff (!rst) $onehot0(release_o));

endmodule

// File: tb/tb_output_port_arbiter.sv
// Bench for output_port_arbiter: table of single-packet arbitrations plus hand-written
// stall, lock, idle-stall, async-reset and fairness sequences; bytes checked via scoreboard.
module tb_output_port_arbiter;

    localparam int N  = 3;
    localparam int PW = 4;
    localparam int UW = 8;

    logic            clk1 = 1'b0;
    logic            rst;
    logic [N-1:0]    req_i = '0;
    logic [N*UW-1:0] rdata_i;
    logic            stop_i = 1'b0;
    logic [PW-1:0]   raddr_o;
    logic [N-1:0]    grant_o;
    logic [N-1:0]    release_o;
    logic [UW-1:0]   pdata_o;
    logic            packet_valid_o;

    int total = 0;
    int bad   = 0;

    logic [7:0] mem [N][16];
    logic [7:0] byte_q [$];
    logic [2:0] rel_q [$];

    typedef struct {
        logic [2:0] req;
        logic [7:0] size;
        logic [2:0] g;
        int         len;
    } vec_t;
    vec_t tbl [7];

    output_port_arbiter #(.N_REQ(N), .PTR_SZ(PW), .UWIDTH(UW)) dut (
        .clk1           (clk1),
        .rst            (rst),
        .req_i          (req_i),
        .rdata_i        (rdata_i),
        .stop_i         (stop_i),
        .raddr_o        (raddr_o),
        .grant_o        (grant_o),
        .release_o      (release_o),
        .pdata_o        (pdata_o),
        .packet_valid_o (packet_valid_o)
    );

    always #5 clk1 = ~clk1;

    always_comb begin
        for (int i = 0; i < N; i++) rdata_i[i*UW +: UW] = mem[i][raddr_o];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk1) begin
        if (rst === 1'b1) begin
            if (packet_valid_o) begin
                if (byte_q.size() == 0) chk("byte_extra", 32'(pdata_o), 32'hFFFF);
                else chk("pdata", pdata_o, byte_q.pop_front());
            end
            if (release_o != '0) begin
                if (rel_q.size() == 0) chk("release_extra", release_o, 0);
                else chk("release", release_o, rel_q.pop_front());
            end
            if (grant_o != '0) chk("grant_onehot", $onehot(grant_o), 1);
        end
    end

    task automatic load(input int g, input logic [7:0] size);
        for (int k = 0; k < 16; k++) mem[g][k] = 8'(g * 64 + k * 29 + 7);
        mem[g][2] = size;
    endtask

    function automatic int gidx(input logic [2:0] g);
        for (int i = 0; i < N; i++) if (g[i]) return i;
        return 0;
    endfunction

    task automatic expect_pkt(input logic [2:0] g, input int len);
        int gi;
        gi = gidx(g);
        for (int k = 0; k < len; k++) byte_q.push_back(mem[gi][k]);
        rel_q.push_back(g);
    endtask

    // Called at the negedge right after the arbitration edge; returns at the release negedge.
    task automatic recv_pkt(input logic [2:0] exp_g, input int len, input int st_addr,
                            input int st_n, input int chg_addr, input logic [2:0] chg_req);
        int cnt = 0;
        int amax = 0;
        bit done = 0;
        bit stalled = 0;
        bit changed = 0;
        chk("grant", grant_o, exp_g);
        for (int c = 0; c < 64 && !done; c++) begin
            @(negedge clk1);
            if (c == 0) chk("first_valid", packet_valid_o, 1);
            if (packet_valid_o) cnt++;
            if (int'(raddr_o) > amax) amax = int'(raddr_o);
            if (release_o != '0) begin
                done = 1;
            end else begin
                if (!changed && chg_addr >= 0 && int'(raddr_o) == chg_addr) begin
                    req_i   = chg_req;
                    changed = 1;
                end
                if (!stalled && st_n > 0 && int'(raddr_o) == st_addr) begin
                    stalled = 1;
                    stop_i  = 1'b1;
                    for (int s = 0; s < st_n; s++) begin
                        @(negedge clk1);
                        chk("stall_valid", packet_valid_o, 0);
                        chk("stall_raddr", raddr_o, st_addr);
                    end
                    stop_i = 1'b0;
                end
            end
        end
        chk("release_seen", done, 1);
        chk("valid_count", cnt, len);
        chk("raddr_max", amax, len - 1);
        chk("grant_cleared", grant_o, 0);
    endtask

    task automatic one_pkt(input logic [2:0] req, input logic [2:0] g, input int len);
        expect_pkt(g, len);
        req_i = req;
        @(negedge clk1);
        chk("arb_gap_valid", packet_valid_o, 0);
        recv_pkt(g, len, -1, 0, -1, '0);
        req_i = '0;
        @(negedge clk1);
        chk("idle_grant", grant_o, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0] fair [4];
        int guard;

        tbl[0] = '{req: 3'b001, size: 8'h02, g: 3'b001, len: 6};
        tbl[1] = '{req: 3'b001, size: 8'h05, g: 3'b001, len: 9};
        tbl[2] = '{req: 3'b101, size: 8'h00, g: 3'b100, len: 4};
        tbl[3] = '{req: 3'b011, size: 8'h07, g: 3'b001, len: 11};
        tbl[4] = '{req: 3'b111, size: 8'h01, g: 3'b010, len: 5};
        tbl[5] = '{req: 3'b011, size: 8'h03, g: 3'b001, len: 7};
        tbl[6] = '{req: 3'b110, size: 8'hFA, g: 3'b010, len: 6};

        for (int g = 0; g < N; g++) load(g, 8'h00);
        rst = 1'b1;
        #1 rst = 1'b0;
        repeat (2) @(negedge clk1);
        chk("rst_grant", grant_o, 0);
        chk("rst_raddr", raddr_o, 0);
        chk("rst_release", release_o, 0);
        chk("rst_pdata", pdata_o, 0);
        chk("rst_valid", packet_valid_o, 0);
        rst = 1'b1;
        @(negedge clk1);

        for (int r = 0; r < 7; r++) begin
            for (int g = 0; g < N; g++) load(g, tbl[r].size);
            if (r == 0) begin
                mem[0][0] = 8'h05; mem[0][1] = 8'h10; mem[0][2] = 8'h02;
                mem[0][3] = 8'hA1; mem[0][4] = 8'hA2; mem[0][5] = 8'hC3;
            end
            one_pkt(tbl[r].req, tbl[r].g, tbl[r].len);
        end

        // Stall for 3 cycles while raddr sits at 4
        load(2, 8'h03);
        expect_pkt(3'b100, 7);
        req_i = 3'b100;
        @(negedge clk1);
        recv_pkt(3'b100, 7, 4, 3, -1, '0);
        req_i = '0;
        @(negedge clk1);

        // stop_i in IDLE holds off arbitration
        load(0, 8'h01);
        expect_pkt(3'b001, 5);
        stop_i = 1'b1;
        req_i  = 3'b001;
        for (int s = 0; s < 3; s++) begin
            @(negedge clk1);
            chk("idle_stop_grant", grant_o, 0);
        end
        stop_i = 1'b0;
        @(negedge clk1);
        chk("idle_stop_valid", packet_valid_o, 0);
        recv_pkt(3'b001, 5, -1, 0, -1, '0);
        req_i = '0;
        @(negedge clk1);

        // Lock: req changes mid-packet are ignored
        load(1, 8'h03);
        load(0, 8'h00);
        expect_pkt(3'b010, 7);
        req_i = 3'b010;
        @(negedge clk1);
        recv_pkt(3'b010, 7, -1, 0, 2, 3'b001);
        expect_pkt(3'b001, 4);
        @(negedge clk1);
        chk("lock_gap_valid", packet_valid_o, 0);
        recv_pkt(3'b001, 4, -1, 0, -1, '0);
        req_i = '0;
        @(negedge clk1);

        // Async reset mid-packet
        load(1, 8'h07);
        expect_pkt(3'b010, 11);
        req_i = 3'b010;
        @(negedge clk1);
        chk("rstmid_grant", grant_o, 3'b010);
        guard = 0;
        while (raddr_o != 4'd3 && guard < 20) begin
            @(negedge clk1);
            guard++;
        end
        chk("rstmid_reach", raddr_o, 3);
        rst = 1'b0;
        #1;
        chk("rstmid_grant0", grant_o, 0);
        chk("rstmid_raddr0", raddr_o, 0);
        chk("rstmid_release0", release_o, 0);
        chk("rstmid_pdata0", pdata_o, 0);
        chk("rstmid_valid0", packet_valid_o, 0);
        byte_q.delete();
        rel_q.delete();
        req_i = 3'b100;
        load(2, 8'h04);
        @(negedge clk1);
        chk("rstmid_hold_release", release_o, 0);
        expect_pkt(3'b100, 8);
        rst = 1'b1;
        @(negedge clk1);
        chk("rstmid_gap_valid", packet_valid_o, 0);
        recv_pkt(3'b100, 8, -1, 0, -1, '0);
        req_i = '0;
        @(negedge clk1);

        // Fairness with all three requesting
        for (int g = 0; g < N; g++) load(g, 8'h00);
        fair[0] = 3'b001; fair[1] = 3'b010; fair[2] = 3'b100; fair[3] = 3'b001;
        for (int p = 0; p < 4; p++) expect_pkt(fair[p], 4);
        req_i = 3'b111;
        @(negedge clk1);
        for (int p = 0; p < 4; p++) begin
            recv_pkt(fair[p], 4, -1, 0, -1, '0);
            if (p == 3) req_i = '0;
            @(negedge clk1);
            chk("fair_gap_valid", packet_valid_o, 0);
        end
        chk("fair_end_grant", grant_o, 0);

        repeat (3) @(negedge clk1);
        chk("byte_q_empty", byte_q.size(), 0);
        chk("rel_q_empty", rel_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
